// File: rtl/dtbdm_window_sequencer.sv
// dtbdm_window_sequencer: builds 3x3 raster windows and sequences the similarity stage over one frame
module dtbdm_window_sequencer #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int CNT_W = 9
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [7:0]  iv8Pixel,
  input  logic        iPixValid,
  output logic        oPixReady,
  output logic [71:0] ov72Window,
  output logic        oWinValid,
  output logic        oSimEn,
  output logic        oBorderAlign,
  output logic        oFrameDone,
  output logic        oBusy
);
  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN, DONE} state_t;
  localparam int TAPS = 2 * IMG_W + 3;
  localparam logic [CNT_W-1:0] W1 = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] W2 = CNT_W'(IMG_W - 2);
  localparam logic [CNT_W-1:0] H1 = CNT_W'(IMG_H - 1);
  state_t state, state_n;
  logic [7:0] sr [TAPS];
  logic [CNT_W-1:0] in_r, in_c, cr, cc;
  logic acc, shift, border, bd1;
  logic [71:0] win;
  assign oPixReady = state == FILL || state == RUN;
  assign oBusy = state != IDLE;
  assign oFrameDone = state == DONE;
  assign acc = iPixValid & oPixReady;
  assign shift = acc | (state == FLUSH);
  assign border = cr == '0 || cr == H1 || cc == '0 || cc == W1;
  // Newest pixel sits at tap 0 = (r+1,c+1); centre (r,c) is always IMG_W+1 taps back.
  assign win = {sr[2*IMG_W+2], sr[2*IMG_W+1], sr[2*IMG_W],
                sr[IMG_W+2], sr[IMG_W+1], sr[IMG_W],
                sr[2], sr[1], sr[0]};
  assign ov72Window = !oWinValid ? '0 : border ? {9{sr[IMG_W+1]}} : win;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = iStart ? FILL : IDLE;
      FILL:  state_n = (acc && in_r == CNT_W'(1) && in_c == '0) ? RUN : FILL;
      RUN:   state_n = (acc && in_r == H1 && in_c == W1) ? FLUSH : RUN;
      FLUSH: state_n = (cr == H1 && cc == W2) ? DRAIN : FLUSH;
      DRAIN: state_n = oWinValid ? DRAIN : DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      oWinValid <= 1'b0;
      oSimEn <= 1'b0;
      bd1 <= 1'b0;
      oBorderAlign <= 1'b0;
      in_r <= '0;
      in_c <= '0;
      cr <= '0;
      cc <= '0;
    end else begin
      state <= state_n;
      oWinValid <= (state == RUN && acc) || state == FLUSH;
      oSimEn <= oWinValid;
      bd1 <= oWinValid & border;
      oBorderAlign <= bd1;
      if (state == IDLE) begin
        in_r <= '0;
        in_c <= '0;
        cr <= '0;
        cc <= '0;
      end else begin
        if (acc) begin
          in_c <= in_c == W1 ? '0 : in_c + 1'b1;
          if (in_c == W1) in_r <= in_r + 1'b1;
        end
        if (oWinValid) begin
          cc <= cc == W1 ? '0 : cc + 1'b1;
          if (cc == W1) cr <= cr + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge iClk) begin
    if (shift) begin
      sr[0] <= iv8Pixel;
      for (int i = 1; i < TAPS; i++) sr[i] <= sr[i-1];
    end
  end
endmodule

// File: tb/tb_dtbdm_window_sequencer.sv
// tb_dtbdm_window_sequencer: directed checks of the window sequencer on a 4x4 frame
module tb_dtbdm_window_sequencer;
  logic iClk, iRst, iStart, iPixValid;
  logic [7:0] iv8Pixel;
  logic oPixReady, oWinValid, oSimEn, oBorderAlign, oFrameDone, oBusy;
  logic [71:0] ov72Window;
  int checks = 0, failures = 0;
  int pix, win_cnt, since, bcnt, dcnt, cyc;
  logic eb1, eb2, prev_wv;

  dtbdm_window_sequencer #(.IMG_W(4), .IMG_H(4), .CNT_W(3)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iv8Pixel(iv8Pixel),
    .iPixValid(iPixValid), .oPixReady(oPixReady), .ov72Window(ov72Window),
    .oWinValid(oWinValid), .oSimEn(oSimEn), .oBorderAlign(oBorderAlign),
    .oFrameDone(oFrameDone), .oBusy(oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic logic [7:0] pv(input int n);
    return 8'(16 * (n / 4) + n % 4);
  endfunction

  function automatic logic is_border(input int n);
    return (n / 4 == 0) || (n / 4 == 3) || (n % 4 == 0) || (n % 4 == 3);
  endfunction

  function automatic logic [71:0] exp_win(input int n);
    if (is_border(n)) return {9{pv(n)}};
    return {pv(n-5), pv(n-4), pv(n-3), pv(n-1), pv(n), pv(n+1), pv(n+3), pv(n+4), pv(n+5)};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit mon);
    logic acc_t;
    acc_t = iPixValid & oPixReady;
    @(posedge iClk);
    if (acc_t) pix++;
    #1;
    cyc++;
    if (mon) begin
      if (since >= 0) since++;
      chk("sim_en", 72'(oSimEn), 72'(prev_wv));
      chk("border_align", 72'(oBorderAlign), 72'(eb2));
      eb2 = eb1;
      eb1 = oWinValid && is_border(win_cnt);
      if (oWinValid) begin
        chk($sformatf("window_%0d", win_cnt), ov72Window, exp_win(win_cnt));
        if (win_cnt == 5) chk("centre_1_1", ov72Window, 72'h00_01_02_10_11_12_20_21_22);
        win_cnt++;
        if (win_cnt == 16) since = 0;
      end
      chk("frame_done", 72'(oFrameDone), 72'(since == 2));
      if (oBorderAlign) bcnt++;
      if (oFrameDone) dcnt++;
      prev_wv = oWinValid;
    end
  endtask

  task automatic run_frame(input bit gaps, input bit keep);
    win_cnt = 0; pix = 0; since = -1; bcnt = 0; dcnt = 0; cyc = 0;
    eb1 = 1'b0; eb2 = 1'b0; prev_wv = 1'b0;
    iStart = 1'b1;
    step(1);
    chk("busy_after_start", 72'(oBusy), 72'(1));
    if (!keep) iStart = 1'b0;
    while (since < 3 && cyc < 300) begin
      chk("pix_ready", 72'(oPixReady), 72'(pix < 16));
      iPixValid = pix < 16 ? (gaps ? 1'($urandom_range(1)) : 1'b1) : gaps;
      iv8Pixel = pix < 16 ? pv(pix) : 8'hEE;
      step(1);
    end
    iPixValid = 1'b0;
    chk("win_count", 72'(win_cnt), 72'(16));
    chk("border_count", 72'(bcnt), 72'(12));
    chk("done_count", 72'(dcnt), 72'(1));
    chk("busy_idle_after_done", 72'(oBusy), 72'(0));
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iPixValid = 1'b0; iv8Pixel = '0;
    pix = 0; cyc = 0;
    step(0);
    step(0);
    chk("reset_outputs", {ov72Window[65:0], oPixReady, oWinValid, oSimEn, oBorderAlign, oFrameDone, oBusy}, '0);
    chk("reset_window", ov72Window, '0);
    iRst = 1'b0;
    step(0);
    chk("idle_ready", 72'(oPixReady), 72'(0));
    run_frame(1'b0, 1'b0);
    step(0);
    run_frame(1'b1, 1'b0);
    step(0);
    pix = 0;
    iStart = 1'b1;
    step(0);
    iStart = 1'b0;
    while (pix < 9 && cyc < 1000) begin
      iPixValid = 1'b1;
      iv8Pixel = pv(pix);
      step(0);
    end
    iPixValid = 1'b0;
    iRst = 1'b1;
    step(0);
    iRst = 1'b0;
    chk("abort_outputs", {ov72Window[65:0], oPixReady, oWinValid, oSimEn, oBorderAlign, oFrameDone, oBusy}, '0);
    chk("abort_window", ov72Window, '0);
    for (int i = 0; i < 4; i++) begin
      step(0);
      chk("abort_no_done", 72'(oFrameDone | oBusy), 72'(0));
    end
    run_frame(1'b0, 1'b0);
    step(0);
    run_frame(1'b0, 1'b1);
    run_frame(1'b0, 1'b1);
    iStart = 1'b0;
    step(0);
    step(0);
    chk("final_idle", 72'(oBusy), 72'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
